usart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one USART transmitter between NUM_REQ frame producers.
- Sits between the producers (sensor framer, status reporter, command echo, ...) and the USART tx_writer side: drives data/valid, observes ready.
- Latches one whole frame per grant and enforces a minimum inter-frame gap.
- Guarantees fair, starvation-free access to the serial link.

---
 rtl/usart_arb_pkg.sv | 22 ++
 rtl/usart_rr_pick.sv | 42 ++++
 rtl/usart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_arb_pkg.sv
// usart_arb_pkg
// Shared types and helpers for the USART transmit arbiter and its round-robin
// picker.
//   arb_state_t : arbiter FSM state encoding (IDLE, SEND, GAP)
//   STAT_WIDTH  : width of each per-requester frame counter (stats build)
//   rr_next     : next round-robin index with wrap-around
package usart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int unsigned STAT_WIDTH = 16;

  // Index that follows idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/usart_rr_pick.sv
// usart_rr_pick
// Purely combinational rotating-priority picker. Finds the first set bit of
// req_i, scanning upward from ptr_i and wrapping past N-1 back to 0.
//   req_i   : request vector, N bits
//   ptr_i   : index with highest priority
//   found_o : at least one request is set
//   idx_o   : index of the winning request (0 when found_o is low)
module usart_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDX_W:0] sum;

  // Rotate so that bit 0 of rot is the request at ptr_i; the lowest set bit
  // of rot is then the winner, offset back by ptr_i modulo N.
  always_comb begin
    dbl     = {req_i, req_i} >> ptr_i;
    rot     = dbl[N-1:0];
    found_o = |rot;
    sum     = '0;
    idx_o   = '0;
    for (int unsigned j = N; j > 0; j--) begin
      if (rot[j-1]) begin
        sum = {1'b0, ptr_i} + (IDX_W+1)'(j - 1);
      end
    end
    if (sum >= (IDX_W+1)'(N)) begin
      idx_o = IDX_W'(32'(sum) - N);
    end else begin
      idx_o = sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter
// Round-robin arbiter sharing one USART transmitter between NUM_REQ frame
// producers. One whole frame is latched per grant, then held on tx_data/tx_valid
// until tx_ready; after each transfer GAP_CYCLES idle cycles are enforced.
// Optional statistics (per-requester saturating frame counters) are built when
// the macro USART_TX_ARB_STATS_EN is defined.
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   req_valid   : per-requester frame valid
//   req_data    : per-requester payloads, requester k at [k*DATA_LENGTH +: DATA_LENGTH]
//   req_ready   : per-requester accept strobe, one-hot or zero (combinational in IDLE)
//   tx_data     : frame to the USART transmitter
//   tx_valid    : frame valid to the USART transmitter
//   tx_ready    : USART transmitter can accept a frame
//   busy        : FSM is outside IDLE
//   grant_id    : index of the last granted requester
//   frame_count : (stats) per-requester completed-frame counters, STAT_WIDTH each
//   stats_clear : (stats) synchronous clear of all counters
module usart_tx_arbiter
  import usart_arb_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = 48,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_LENGTH-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
`ifdef USART_TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0]  frame_count,
  input  logic                           stats_clear
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t             state_q;
  logic [ID_W-1:0]        ptr_q;
  logic [ID_W-1:0]        grant_q;
  logic [DATA_LENGTH-1:0] tx_data_q;
  logic                   tx_valid_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       gap_q;

  logic                   pick_found;
  logic [ID_W-1:0]        pick_idx;
  logic [DATA_LENGTH-1:0] pick_data;
  logic                   grant_now;
  logic                   tx_done;

  usart_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_now = (state_q == IDLE) && pick_found;
  assign tx_done   = (state_q == SEND) && tx_ready;

  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == pick_idx) begin
        pick_data = req_data[k*DATA_LENGTH +: DATA_LENGTH];
      end
    end
  end

  // The accept strobe has to land in the same cycle the pick is made, so it
  // is the only output not taken from a register.
  always_comb begin
    req_ready = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_now && (ID_W'(k) == pick_idx)) begin
        req_ready[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            tx_data_q  <= pick_data;
            grant_q    <= pick_idx;
            ptr_q      <= ID_W'(rr_next(32'(pick_idx), NUM_REQ));
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            if (GAP_CYCLES > 0) begin
              // Counter runs GAP_CYCLES-1 down to 0 inclusive: GAP_CYCLES cycles.
              gap_q   <= CNT_W'(GAP_CYCLES - 1);
              state_q <= GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

`ifdef USART_TX_ARB_STATS_EN
  logic [NUM_REQ*STAT_WIDTH-1:0] cnt_q;

  // Counted on tx completion, attributed to the requester held in grant_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (stats_clear) begin
      cnt_q <= '0;
    end else if (tx_done) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if ((ID_W'(k) == grant_q) && (cnt_q[k*STAT_WIDTH +: STAT_WIDTH] != '1)) begin
          cnt_q[k*STAT_WIDTH +: STAT_WIDTH] <= cnt_q[k*STAT_WIDTH +: STAT_WIDTH] + 1'b1;
        end
      end
    end
  end

  assign frame_count = cnt_q;
`endif

endmodule

// File: tb/tb_usart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_usart_tx_arbiter;

  localparam int DL  = 48;
  localparam int NR  = 4;
  localparam int GAP = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR*DL-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [DL-1:0]   tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic            busy;
  logic [1:0]      grant_id;
`ifdef USART_TX_ARB_STATS_EN
  logic [NR*16-1:0] frame_count;
  logic             stats_clear;
`endif

  always #5 clk = ~clk;

  usart_tx_arbiter #(
    .DATA_LENGTH (DL),
    .NUM_REQ     (NR),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .grant_id    (grant_id)
`ifdef USART_TX_ARB_STATS_EN
    ,
    .frame_count (frame_count),
    .stats_clear (stats_clear)
`endif
  );

  typedef struct packed {
    logic [1:0]    id;
    logic [DL-1:0] data;
  } exp_t;

  logic [DL-1:0] D [NR] = '{48'h0000_1111_0000, 48'hA5A5_0000_0001,
                            48'h2222_BEEF_0002, 48'h3333_CAFE_0003};

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id);
    expq.push_back('{id: 2'(id), data: D[id]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next accept strobe and compares it; returns just after the
  // grant edge so the caller can withdraw the accepted request.
  task automatic grant_wait(input int id, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    chk(nm, 64'(req_ready), 64'(4'b0001 << id));
    tick();
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Monitor / scoreboard: pops an expected frame on every tx handshake and
  // watches the hold rule and strobe shape.
  logic [DL-1:0] hold_data;
  bit            hold_pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (hold_pend && tx_valid) chk("tx_data_stable", 64'(tx_data), 64'(hold_data));
      if (tx_valid && tx_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got id %0d data %0h expected no frame", grant_id, tx_data);
        end else begin
          e = expq.pop_front();
          chk("frame_data", 64'(tx_data), 64'(e.data));
          chk("frame_id", 64'(grant_id), 64'(e.id));
        end
      end
      hold_pend = tx_valid && !tx_ready;
      hold_data = tx_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    tx_ready  = 1'b0;
    req_data  = {D[3], D[2], D[1], D[0]};
`ifdef USART_TX_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    // Single requester 1: same-cycle accept, 1-cycle latency, 8-cycle gap
    tick();
    req_valid = 4'b0010;
    tx_ready  = 1'b1;
    push(1);
    @(negedge clk);
    chk("t1_ready_same_cycle", 64'(req_ready), 64'h2);
    chk("t1_busy_in_idle", 64'(busy), 64'd0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_tx_valid", 64'(tx_valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant_id", 64'(grant_id), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_gap_busy", 64'(busy), 64'd1);
      chk("t1_gap_tx_valid", 64'(tx_valid), 64'd0);
    end
    @(negedge clk);
    chk("t1_busy_low_after_10", 64'(busy), 64'd0);

    // All four continuously valid: 0,1,2,3,0,1 with single-cycle strobes
    do_reset();
    req_valid = 4'b1111;
    tx_ready  = 1'b1;
    push(0); push(1); push(2); push(3); push(0); push(1);
    for (int k = 0; k < 6; k++) begin
      grant_wait(k % 4, "t2_rr_grant");
      if (k == 5) req_valid = '0;
      @(negedge clk);
      chk("t2_pulse_one_cycle", 64'(req_ready), 64'd0);
    end
    wait_idle("t2_idle");

    // Requester 2 with tx_ready held low for 20 cycles; requester 0 waits out the gap
    tick();
    tx_ready  = 1'b0;
    req_valid = 4'b0100;
    push(2);
    grant_wait(2, "t3_grant2");
    req_valid = 4'b0001;
    push(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(tx_valid), 64'd1);
      chk("t3_hold_data", 64'(tx_data), 64'(D[2]));
      chk("t3_no_grant_send", 64'(req_ready), 64'd0);
    end
    tick();
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t3_xfer_valid", 64'(tx_valid), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_no_grant_gap", 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    chk("t3_grant_after_gap", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    wait_idle("t3_idle");

    // Drive pointer to 3, then 0 and 2 together: wrap to 0 first
    tick();
    req_valid = 4'b0100;
    push(2);
    grant_wait(2, "t4_set_ptr3");
    req_valid = '0;
    wait_idle("t4_idle_a");
    tick();
    req_valid = 4'b0101;
    push(0); push(2);
    grant_wait(0, "t4_wrap_grant0");
    req_valid = 4'b0100;
    grant_wait(2, "t4_then_grant2");
    req_valid = '0;
    wait_idle("t4_idle_b");

    // Asynchronous reset during SEND drops the frame
    tick();
    tx_ready  = 1'b0;
    req_valid = 4'b0010;
    grant_wait(1, "t5_grant1");
    req_valid = '0;
    @(negedge clk);
    chk("t5_sending", 64'(tx_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_tx_valid", 64'(tx_valid), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_tx_data", 64'(tx_data), 64'd0);
    tick();
    tick();
    reset_n   = 1'b1;
    req_valid = 4'b1001;
    tx_ready  = 1'b1;
    push(0); push(3);
    grant_wait(0, "t5_first_after_reset");
    req_valid = 4'b1000;
    grant_wait(3, "t5_second_after_reset");
    req_valid = '0;
    wait_idle("t5_idle");

`ifdef USART_TX_ARB_STATS_EN
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tick();
      req_valid = 4'b0010;
      push(1);
      grant_wait(1, "s_grant1");
      req_valid = '0;
      wait_idle("s_idle");
    end
    chk("s_count3", 64'(frame_count), 64'h0000_0000_0003_0000);
    tick();
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    @(negedge clk);
    chk("s_cleared", 64'(frame_count), 64'd0);
    force dut.cnt_q = 64'h0000_0000_FFFF_0000;
    tick();
    release dut.cnt_q;
    req_valid = 4'b0010;
    push(1);
    grant_wait(1, "s_grant_sat");
    req_valid = '0;
    wait_idle("s_idle_sat");
    chk("s_saturate", 64'(frame_count), 64'h0000_0000_FFFF_0000);
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
